mem_wb_pipe_latch: RTL and testbench

MEM_WB_PIPE_LATCH -- requirements
Module: mem_wb_pipe_latch

---
 rtl/mem_wb_pipe_latch_if.sv | 50 +++++
 rtl/mem_wb_pipe_latch.sv | 176 +++++++++++++++++
 tb/tb_mem_wb_pipe_latch.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_pipe_latch_if.sv
// ----------------------------------------------------------------------------
// mem_wb_pipe_latch_if
// Bundles the MEM/WB pipeline latch bus: advance/squash controls, the incoming
// instruction payload, the outgoing payload and the status/statistics outputs.
//   master : the upstream side driving the latch and observing its outputs
//   slave  : the latch itself
// DATA_W must match the DATA_W of the mem_wb_pipe_latch bound to this bus.
// ----------------------------------------------------------------------------
interface mem_wb_pipe_latch_if #(
    parameter int DATA_W = 32
);
    // Pipeline controls
    logic                  en;
    logic                  flush;
    logic                  dhit;

    // Incoming instruction
    logic                  in_valid;
    logic [5:0]            in_ctrl;   // {datomic, MemtoReg, JAL, Jump, halt, regWEN}
    logic [4:0]            in_wsel;
    logic [3*DATA_W-1:0]   in_word;   // {pc_plus_4, portout, jaddr}
    logic [DATA_W-1:0]     in_dload;

    // Outgoing instruction (last stage)
    logic                  out_valid;
    logic [5:0]            out_ctrl;
    logic [4:0]            out_wsel;
    logic [3*DATA_W-1:0]   out_word;
    logic [DATA_W-1:0]     out_dload;

    // Status and statistics
    logic                  out_halt;
    logic [2:0]            occupancy;
    logic [15:0]           stall_cnt;
    logic [15:0]           flush_cnt;

    modport master (
        output en, flush, dhit,
        output in_valid, in_ctrl, in_wsel, in_word, in_dload,
        input  out_valid, out_ctrl, out_wsel, out_word, out_dload,
        input  out_halt, occupancy, stall_cnt, flush_cnt
    );

    modport slave (
        input  en, flush, dhit,
        input  in_valid, in_ctrl, in_wsel, in_word, in_dload,
        output out_valid, out_ctrl, out_wsel, out_word, out_dload,
        output out_halt, occupancy, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/mem_wb_pipe_latch.sv
// ----------------------------------------------------------------------------
// mem_wb_pipe_latch
// MEM/WB pipeline register of DEPTH stages (1..4). Each enabled edge shifts the
// instruction one stage; flush squashes valid/ctrl of every stage while keeping
// the payload; a stalled stage 0 can still capture late load data on a cache
// hit. Outputs come from the last stage with ctrl masked on bubbles.
// out_halt is sticky until reset.
//
// Optional feature: define MEMLATCH_STATS_EN to build saturating 16-bit
// stall/flush event counters; otherwise stall_cnt/flush_cnt are tied to 0 and
// no counter registers exist.
// ----------------------------------------------------------------------------
module mem_wb_pipe_latch #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1
) (
    input  logic               CLK,
    input  logic               RST,
    mem_wb_pipe_latch_if.slave bus
);

    // ------------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------------
    if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
        $error("mem_wb_pipe_latch: DEPTH=%0d outside legal range 1..4", DEPTH);
    end

    localparam int LAST          = DEPTH - 1;
    localparam int CTRL_HALT     = 1;
    localparam int CTRL_MEMTOREG = 4;

    // One pipeline stage worth of state
    typedef struct packed {
        logic                valid;
        logic [5:0]          ctrl;
        logic [4:0]          wsel;
        logic [3*DATA_W-1:0] word;
        logic [DATA_W-1:0]   dload;
    } stage_t;

    stage_t     stage_q [DEPTH];
    stage_t     stage_d [DEPTH];
    logic       halt_q;
    logic       halt_d;
    logic [2:0] occ_count;

    // ------------------------------------------------------------------------
    // Stage next-state: flush beats advance, advance beats stall capture
    // ------------------------------------------------------------------------
    // NOTE: every stage_d field is given its hold value first, so no path
    // through this block leaves a bit unassigned and no latch is inferred.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end

        if (bus.flush) begin
            // Squash: kill valid and ctrl everywhere, payload stays put
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i].valid = 1'b0;
                stage_d[i].ctrl  = '0;
            end
        end else if (bus.en) begin
            // Advance: stage 0 takes the new instruction, others shift down
            stage_d[0].valid = bus.in_valid;
            stage_d[0].ctrl  = bus.in_ctrl;
            stage_d[0].wsel  = bus.in_wsel;
            stage_d[0].word  = bus.in_word;
            stage_d[0].dload = bus.in_dload;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end else if (bus.dhit && stage_q[0].valid && stage_q[0].ctrl[CTRL_MEMTOREG]) begin
            // Stalled: a load parked in stage 0 picks up its late cache data
            stage_d[0].dload = bus.in_dload;
        end
    end

    // ------------------------------------------------------------------------
    // Stage registers
    // ------------------------------------------------------------------------
    // NOTE: the whole stage array, payload included, is reset so that a
    // freshly reset latch presents all-zero outputs rather than stale data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignment keeps every stage sampling the
            // pre-edge value of its neighbour, which is what makes it a shift.
            stage_q <= stage_d;
        end
    end

    // ------------------------------------------------------------------------
    // Sticky halt: set once a valid halt sits in the last stage
    // ------------------------------------------------------------------------
    always_comb begin
        halt_d = halt_q | (stage_d[LAST].valid & stage_d[LAST].ctrl[CTRL_HALT]);
    end

    // Halt flag register, cleared only by reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Occupancy: population count of the stage valid bits
    // ------------------------------------------------------------------------
    always_comb begin
        occ_count = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ_count = occ_count + 3'(stage_q[i].valid);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs from the last stage; bubbles never carry control
    // ------------------------------------------------------------------------
    assign bus.out_valid = stage_q[LAST].valid;
    assign bus.out_ctrl  = stage_q[LAST].valid ? stage_q[LAST].ctrl : 6'd0;
    assign bus.out_wsel  = stage_q[LAST].wsel;
    assign bus.out_word  = stage_q[LAST].word;
    assign bus.out_dload = stage_q[LAST].dload;
    assign bus.out_halt  = halt_q;
    assign bus.occupancy = occ_count;

    // ------------------------------------------------------------------------
    // Event statistics
    // ------------------------------------------------------------------------
`ifdef MEMLATCH_STATS_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] stall_cnt_d;
    logic [15:0] flush_cnt_q;
    logic [15:0] flush_cnt_d;

    // Saturating counters: flush edges, and stalled edges with work in flight
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.flush) begin
            if (flush_cnt_q != 16'hFFFF) begin
                flush_cnt_d = flush_cnt_q + 16'd1;
            end
        end else if (!bus.en && occ_count != 3'd0) begin
            if (stall_cnt_q != 16'hFFFF) begin
                stall_cnt_d = stall_cnt_q + 16'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
`else
    assign bus.stall_cnt = 16'd0;
    assign bus.flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_latch.sv
// ----------------------------------------------------------------------------
// tb_mem_wb_pipe_latch
// Drives four latches (DEPTH 1..4) from one shared stimulus and compares every
// output against a queue-based reference model of the latch rules.
// Honours MEMLATCH_STATS_EN for the expected counter values.
// ----------------------------------------------------------------------------
module tb_mem_wb_pipe_latch;

    localparam int DW   = 32;
    localparam int NDUT = 4;

`ifdef MEMLATCH_STATS_EN
    localparam bit STATS  = 1'b1;
    localparam int N_LONG = 70000;
`else
    localparam bit STATS  = 1'b0;
    localparam int N_LONG = 500;
`endif

    typedef struct packed {
        logic            valid;
        logic [5:0]      ctrl;
        logic [4:0]      wsel;
        logic [3*DW-1:0] word;
        logic [DW-1:0]   dload;
    } stage_t;

    typedef struct packed {
        logic            valid;
        logic [5:0]      ctrl;
        logic [4:0]      wsel;
        logic [3*DW-1:0] word;
        logic [DW-1:0]   dload;
        logic            halt;
        logic [2:0]      occ;
        logic [15:0]     stall;
        logic [15:0]     flush;
    } obs_t;

    // Shared stimulus
    logic            clk;
    logic            rst;
    logic            en;
    logic            flush;
    logic            dhit;
    logic            in_valid;
    logic [5:0]      in_ctrl;
    logic [4:0]      in_wsel;
    logic [3*DW-1:0] in_word;
    logic [DW-1:0]   in_dload;

    obs_t obs [NDUT];

    // Reference model state: pipe[d][i] is stage i of the DEPTH=d+1 latch
    stage_t pipe    [NDUT][$];
    bit     halt_m  [NDUT];
    int     stall_m [NDUT];
    int     flush_m [NDUT];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        mem_wb_pipe_latch_if #(.DATA_W(DW)) bus ();

        assign bus.en       = en;
        assign bus.flush    = flush;
        assign bus.dhit     = dhit;
        assign bus.in_valid = in_valid;
        assign bus.in_ctrl  = in_ctrl;
        assign bus.in_wsel  = in_wsel;
        assign bus.in_word  = in_word;
        assign bus.in_dload = in_dload;

        mem_wb_pipe_latch #(.DATA_W(DW), .DEPTH(g + 1)) u_dut (
            .CLK (clk),
            .RST (rst),
            .bus (bus)
        );

        assign obs[g] = {bus.out_valid, bus.out_ctrl, bus.out_wsel, bus.out_word,
                         bus.out_dload, bus.out_halt, bus.occupancy,
                         bus.stall_cnt, bus.flush_cnt};
    end

    // ------------------------------------------------------------------------
    // Comparison primitive
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    function automatic int valid_count(input int d);
        int n = 0;
        for (int i = 0; i <= d; i++) n += int'(pipe[d][i].valid);
        return n;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            pipe[d].delete();
            for (int i = 0; i <= d; i++) pipe[d].push_back('0);
            halt_m[d]  = 1'b0;
            stall_m[d] = 0;
            flush_m[d] = 0;
        end
    endtask

    // Apply one clock edge using the inputs presented at that edge
    task automatic model_edge();
        stage_t s;
        int     occ;
        for (int d = 0; d < NDUT; d++) begin
            occ = valid_count(d);
            if (flush) begin
                for (int i = 0; i <= d; i++) begin
                    s = pipe[d][i];
                    s.valid = 1'b0;
                    s.ctrl  = '0;
                    pipe[d][i] = s;
                end
                if (flush_m[d] < 65535) flush_m[d]++;
            end else if (en) begin
                s = '{valid: in_valid, ctrl: in_ctrl, wsel: in_wsel,
                      word: in_word, dload: in_dload};
                pipe[d].push_front(s);
                void'(pipe[d].pop_back());
            end else begin
                if (occ > 0 && stall_m[d] < 65535) stall_m[d]++;
                s = pipe[d][0];
                if (dhit && s.valid && s.ctrl[4]) begin
                    s.dload = in_dload;
                    pipe[d][0] = s;
                end
            end
            s = pipe[d][d];
            if (s.valid && s.ctrl[1]) halt_m[d] = 1'b1;
        end
    endtask

    // Compare every output of every latch against the model
    task automatic check_all();
        stage_t e;
        for (int d = 0; d < NDUT; d++) begin
            e = pipe[d][d];
            check($sformatf("d%0d out_valid", d + 1), 128'(obs[d].valid), 128'(e.valid));
            check($sformatf("d%0d out_ctrl", d + 1), 128'(obs[d].ctrl),
                  128'(e.valid ? e.ctrl : 6'd0));
            check($sformatf("d%0d out_wsel", d + 1), 128'(obs[d].wsel), 128'(e.wsel));
            check($sformatf("d%0d out_word", d + 1), 128'(obs[d].word), 128'(e.word));
            check($sformatf("d%0d out_dload", d + 1), 128'(obs[d].dload), 128'(e.dload));
            check($sformatf("d%0d out_halt", d + 1), 128'(obs[d].halt), 128'(halt_m[d]));
            check($sformatf("d%0d occupancy", d + 1), 128'(obs[d].occ), 128'(valid_count(d)));
            check($sformatf("d%0d stall_cnt", d + 1), 128'(obs[d].stall),
                  128'(STATS ? stall_m[d] : 0));
            check($sformatf("d%0d flush_cnt", d + 1), 128'(obs[d].flush),
                  128'(STATS ? flush_m[d] : 0));
        end
    endtask

    // One clock edge: update model at the edge, sample 1 time unit later
    task automatic tick(input bit do_check);
        @(posedge clk);
        model_edge();
        #1;
        if (do_check) check_all();
    endtask

    // Asynchronous reset pulse placed between clock edges
    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_all();
        #1;
        rst = 1'b0;
    endtask

    task automatic set_idle();
        en       = 1'b0;
        flush    = 1'b0;
        dhit     = 1'b0;
        in_valid = 1'b0;
        in_ctrl  = '0;
        in_wsel  = '0;
        in_word  = '0;
        in_dload = '0;
    endtask

    // ------------------------------------------------------------------------
    // Directed and randomized sequence
    // ------------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        set_idle();
        model_reset();

        // Reset state while held in reset
        #3;
        check_all();
        #4;
        rst = 1'b0;

        // Two-stage latency of a single instruction through DEPTH=2
        en       = 1'b1;
        in_valid = 1'b1;
        in_wsel  = 5'd7;
        in_word  = {32'h0000_0104, 32'h0, 32'h0};
        tick(1'b1);
        check("d2 occ after 1 edge", 128'(obs[1].occ), 128'(3'd1));
        check("d2 out_valid after 1 edge", 128'(obs[1].valid), 128'(1'b0));
        tick(1'b1);
        check("d2 occ after 2 edges", 128'(obs[1].occ), 128'(3'd2));
        check("d2 out_valid after 2 edges", 128'(obs[1].valid), 128'(1'b1));
        check("d2 out_wsel after 2 edges", 128'(obs[1].wsel), 128'(5'd7));
        check("d2 pc_plus_4 after 2 edges", 128'(obs[1].word[3*DW-1:2*DW]), 128'(32'h104));

        // Randomized traffic with a reset landing mid-run
        for (int i = 0; i < 400; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 19) == 0);
            dhit     = 1'($urandom);
            in_valid = 1'($urandom);
            in_ctrl  = 6'($urandom) & 6'b111101;
            if ($urandom_range(0, 63) == 0) in_ctrl[1] = 1'b1;
            in_wsel  = 5'($urandom);
            in_word  = {$urandom, $urandom, $urandom};
            in_dload = $urandom;
            tick(1'b1);
            if (i == 200) pulse_reset();
        end

        // Fill three stages, flush with en=1, expect an empty pipe
        set_idle();
        pulse_reset();
        en       = 1'b1;
        in_valid = 1'b1;
        in_ctrl  = 6'b000001;
        repeat (3) begin
            in_wsel = 5'($urandom);
            in_word = {$urandom, $urandom, $urandom};
            tick(1'b1);
        end
        check("d3 occ full", 128'(obs[2].occ), 128'(3'd3));
        flush = 1'b1;
        tick(1'b1);
        flush = 1'b0;
        en    = 1'b0;
        check("d3 occ after flush", 128'(obs[2].occ), 128'(3'd0));
        check("d3 out_valid after flush", 128'(obs[2].valid), 128'(1'b0));
        check("d3 out_ctrl after flush", 128'(obs[2].ctrl), 128'(6'd0));
        check("d3 flush_cnt after flush", 128'(obs[2].flush), 128'(STATS ? 16'd1 : 16'd0));

        // Late load data captured while stalled, DEPTH=1
        set_idle();
        pulse_reset();
        en       = 1'b1;
        in_valid = 1'b1;
        in_ctrl  = 6'b010000;
        in_wsel  = 5'd9;
        in_word  = {32'h1111_0000, 32'h2222_0000, 32'h3333_0000};
        in_dload = 32'h0;
        tick(1'b1);
        en       = 1'b0;
        dhit     = 1'b1;
        in_valid = 1'b0;
        in_ctrl  = 6'b000000;
        in_wsel  = 5'd3;
        in_dload = 32'hDEAD_BEEF;
        tick(1'b1);
        check("d1 late dload", 128'(obs[0].dload), 128'(32'hDEAD_BEEF));
        check("d1 wsel held", 128'(obs[0].wsel), 128'(5'd9));
        check("d1 ctrl held", 128'(obs[0].ctrl), 128'(6'b010000));
        check("d1 word held", 128'(obs[0].word),
              128'({32'h1111_0000, 32'h2222_0000, 32'h3333_0000}));

        // Sticky halt through flush and stalls, cleared by async reset
        set_idle();
        pulse_reset();
        en       = 1'b1;
        in_valid = 1'b1;
        in_ctrl  = 6'b000010;
        tick(1'b1);
        in_valid = 1'b0;
        in_ctrl  = 6'b000000;
        repeat (3) tick(1'b1);
        flush = 1'b1;
        tick(1'b1);
        flush = 1'b0;
        en    = 1'b0;
        repeat (10) tick(1'b1);
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("d%0d halt sticky", d + 1), 128'(obs[d].halt), 128'(1'b1));
        end
        #2;
        rst = 1'b1;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("d%0d halt async clear", d + 1), 128'(obs[d].halt), 128'(1'b0));
        end
        model_reset();
        check_all();
        #1;
        rst = 1'b0;

        // Long stall with work in flight: counter saturation
        set_idle();
        en       = 1'b1;
        in_valid = 1'b1;
        repeat (4) tick(1'b1);
        en       = 1'b0;
        in_valid = 1'b0;
        repeat (N_LONG) tick(1'b0);
        #1;
        check_all();
        for (int d = 0; d < NDUT; d++) begin
            check($sformatf("d%0d stall_cnt long", d + 1), 128'(obs[d].stall),
                  128'(STATS ? 16'hFFFF : 16'h0000));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
